multicycle_adder: RTL and testbench



---
 rtl/multicycle_adder_pkg.sv | 14 +
 rtl/multicycle_adder_digit_adder.sv | 25 ++
 rtl/multicycle_adder.sv | 134 +++++++++++++
 tb/tb_multicycle_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_adder_pkg.sv
// Shared types and helpers for the multi-cycle ripple adder.
package multicycle_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Slice counter width; a single-slice adder still needs one counter bit.
  function automatic int cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/multicycle_adder_digit_adder.sv
// Combinational DIGIT-bit ripple of full-add cells; also exposes the carry into its MSB.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign s[i]       = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
  end

  assign co       = w_c[DIGIT];
  assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/multicycle_adder.sv
// Adds A+B+CIN DIGIT bits per clock with a registered inter-slice carry; start/busy/done handshake.
// Build option OVERFLOW_EN adds the signed-overflow output V.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
`ifdef OVERFLOW_EN
  output logic             C,
  output logic             V
`else
  output logic             C
`endif
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] CNT_INIT = CW'(NSLICE - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             w_last;
  logic [DIGIT-1:0] w_sum;
  logic             w_co;
  logic [WIDTH-1:0] w_res_next;
`ifdef OVERFLOW_EN
  logic             w_c_msb_in;
  logic             r_v;
`else
  logic             w_c_msb_unused;
`endif

  digit_adder #(
    .DIGIT    (DIGIT)
  ) u_digit (
    .a        (r_a[DIGIT-1:0]),
    .b        (r_b[DIGIT-1:0]),
    .ci       (r_carry),
    .s        (w_sum),
    .co       (w_co),
`ifdef OVERFLOW_EN
    .c_msb_in (w_c_msb_in)
`else
    .c_msb_in (w_c_msb_unused)
`endif
  );

  // New slice enters at the MSB end; after NSLICE shifts the result is aligned.
  assign w_res_next = WIDTH'({w_sum, r_res} >> DIGIT);
  assign w_last     = (r_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = RUN;
      RUN:     if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_c     <= 1'b0;
`ifdef OVERFLOW_EN
      r_v     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= CIN;
            r_cnt   <= CNT_INIT;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_co;
          r_res   <= w_res_next;
          if (w_last) begin
            r_s    <= w_res_next;
            r_c    <= w_co;
            r_done <= 1'b1;
`ifdef OVERFLOW_EN
            r_v    <= w_c_msb_in ^ w_co;
`endif
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign S    = r_s;
  assign C    = r_c;
`ifdef OVERFLOW_EN
  assign V    = r_v;
`endif

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three instances (DIGIT=1,4,8) checked every cycle against a transaction-level model.
module tb_multicycle_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;

  logic       d_busy [3];
  logic       d_done [3];
  logic [7:0] d_s    [3];
  logic       d_c    [3];
  logic       d_v    [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .CIN(cin),
    .busy(d_busy[0]), .done(d_done[0]), .S(d_s[0]),
`ifdef OVERFLOW_EN
    .C(d_c[0]), .V(d_v[0])
`else
    .C(d_c[0])
`endif
  );

  multicycle_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .CIN(cin),
    .busy(d_busy[1]), .done(d_done[1]), .S(d_s[1]),
`ifdef OVERFLOW_EN
    .C(d_c[1]), .V(d_v[1])
`else
    .C(d_c[1])
`endif
  );

  multicycle_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .CIN(cin),
    .busy(d_busy[2]), .done(d_done[2]), .S(d_s[2]),
`ifdef OVERFLOW_EN
    .C(d_c[2]), .V(d_v[2])
`else
    .C(d_c[2])
`endif
  );

`ifndef OVERFLOW_EN
  initial for (int k = 0; k < 3; k++) d_v[k] = 1'b0;
`endif

  function automatic int ns(input int k);
    return (k == 0) ? 8 : (k == 1) ? 2 : 1;
  endfunction

  // Transaction-level model: a captured sum becomes visible NSLICE edges after acceptance.
  logic [8:0] w_tb_sum;
  logic       w_tb_ovf;
  assign w_tb_sum = {1'b0, a} + {1'b0, b} + {8'b0, cin};
  assign w_tb_ovf = (a[7] == b[7]) && (w_tb_sum[7] != a[7]);

  logic       m_busy [3];
  logic       m_done [3];
  logic [7:0] m_s    [3];
  logic       m_c    [3];
  logic       m_v    [3];
  logic [7:0] m_ps   [3];
  logic       m_pc   [3];
  logic       m_pv   [3];
  int         m_left [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_s[k] <= 8'h00;
        m_c[k] <= 1'b0; m_v[k] <= 1'b0; m_left[k] <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_busy[k]) begin
          m_left[k] <= m_left[k] - 1;
          if (m_left[k] == 1) begin
            m_busy[k] <= 1'b0; m_done[k] <= 1'b1;
            m_s[k] <= m_ps[k]; m_c[k] <= m_pc[k]; m_v[k] <= m_pv[k];
          end
        end else if (start) begin
          m_busy[k] <= 1'b1; m_left[k] <= ns(k);
          m_ps[k] <= w_tb_sum[7:0]; m_pc[k] <= w_tb_sum[8]; m_pv[k] <= w_tb_ovf;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  int done_cnt  [3] = '{0, 0, 0};
  int last_done [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (d_done[k] === 1'b1) begin
        done_cnt[k]  <= done_cnt[k] + 1;
        last_done[k] <= cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy[%0d]", k), 32'(d_busy[k]), 32'(m_busy[k]));
        chk($sformatf("done[%0d]", k), 32'(d_done[k]), 32'(m_done[k]));
        chk($sformatf("S[%0d]", k),    32'(d_s[k]),    32'(m_s[k]));
        chk($sformatf("C[%0d]", k),    32'(d_c[k]),    32'(m_c[k]));
`ifdef OVERFLOW_EN
        chk($sformatf("V[%0d]", k),    32'(d_v[k]),    32'(m_v[k]));
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    start_cyc = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    while (d_done[k] !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    chk($sformatf("done_wait[%0d]", k), 32'(d_done[k]), 32'd1);
  endtask

  int n0;
  logic [8:0] exp_sum;

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    step(2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy[%0d]", k), 32'(d_busy[k]), 32'd0);
      chk($sformatf("rst_done[%0d]", k), 32'(d_done[k]), 32'd0);
      chk($sformatf("rst_S[%0d]", k),    32'(d_s[k]),    32'd0);
      chk($sformatf("rst_C[%0d]", k),    32'(d_c[k]),    32'd0);
    end
    chk_en = 1'b1;
    rst = 1'b0;
    step(1);

    // Full carry ripple
    go(8'hFF, 8'h01, 1'b0);
    wait_done(0, 20);
    chk("ripple_lat_d1", 32'(cyc - start_cyc), 32'd9);
    chk("ripple_lat_d4", 32'(last_done[1] - start_cyc), 32'd3);
    chk("ripple_lat_d8", 32'(last_done[2] - start_cyc), 32'd2);
    chk("ripple_S", 32'(d_s[0]), 32'h00);
    chk("ripple_C", 32'(d_c[0]), 32'd1);
    step(1);

    // Wider slice
    go(8'h3C, 8'h0F, 1'b1);
    wait_done(1, 10);
    chk("wide_lat_d4", 32'(cyc - start_cyc), 32'd3);
    chk("wide_S_d4", 32'(d_s[1]), 32'h4C);
    chk("wide_C_d4", 32'(d_c[1]), 32'd0);
    step(10);
    chk("wide_S_d1", 32'(d_s[0]), 32'h4C);

    // Start while busy is ignored
    n0 = done_cnt[0];
    go(8'h10, 8'h20, 1'b0);
    step(2);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    step(1);
    start = 1'b0;
    step(12);
    chk("busy_start_dones", 32'(done_cnt[0] - n0), 32'd1);
    chk("busy_start_S", 32'(d_s[0]), 32'h30);
    chk("busy_start_C", 32'(d_c[0]), 32'd0);

    // Back-to-back: start presented in the done cycle
    go(8'h10, 8'h05, 1'b0);
    wait_done(0, 20);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    start_cyc = cyc;
    step(1);
    start = 1'b0;
    chk("b2b_accepted", 32'(d_busy[0]), 32'd1);
    wait_done(0, 20);
    chk("b2b_lat", 32'(cyc - start_cyc), 32'd9);
    chk("b2b_S", 32'(d_s[0]), 32'h02);
    step(1);

    // Reset mid-run discards the in-flight result
    n0 = done_cnt[0];
    go(8'h55, 8'h0F, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);
    chk("midrst_busy", 32'(d_busy[0]), 32'd0);
    chk("midrst_done", 32'(d_done[0]), 32'd0);
    chk("midrst_S", 32'(d_s[0]), 32'd0);
    chk("midrst_C", 32'(d_c[0]), 32'd0);
    rst = 1'b0;
    step(12);
    chk("midrst_no_done", 32'(done_cnt[0] - n0), 32'd0);

    // Signed overflow cases
    go(8'h7F, 8'h01, 1'b0);
    step(12);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ovf1_S[%0d]", k), 32'(d_s[k]), 32'h80);
      chk($sformatf("ovf1_C[%0d]", k), 32'(d_c[k]), 32'd0);
`ifdef OVERFLOW_EN
      chk($sformatf("ovf1_V[%0d]", k), 32'(d_v[k]), 32'd1);
`endif
    end
    go(8'h80, 8'h80, 1'b0);
    step(12);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ovf2_S[%0d]", k), 32'(d_s[k]), 32'h00);
      chk($sformatf("ovf2_C[%0d]", k), 32'(d_c[k]), 32'd1);
`ifdef OVERFLOW_EN
      chk($sformatf("ovf2_V[%0d]", k), 32'(d_v[k]), 32'd1);
`endif
    end

    // Single-slice regression on random vectors
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      exp_sum = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      go(ra, rb, rc);
      step(1);
      chk("rand_done_d8", 32'(d_done[2]), 32'd1);
      chk("rand_sum_d8", 32'({d_c[2], d_s[2]}), 32'(exp_sum));
    end
    step(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
